// File: rtl/bennett_inst_sequencer.sv
// Instruction sequencer behind bennett_clock: fetches words over req/gnt/rvalid and commits one per inst_flag.
// Define BENNETT_PREFETCH_EN for a two-entry prefetch buffer (default: single entry).
module bennett_inst_sequencer #(
    parameter int              PHASES   = 4,
    parameter int              AW       = 16,
    parameter int              IW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter logic [IW-1:0]   NOP_INST = '0,
    parameter int              SCW      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inst_flag,
    input  logic [PHASES-1:0] clkp,
    input  logic              pc_load,
    input  logic [AW-1:0]     pc_target,
    output logic              imem_req,
    output logic [AW-1:0]     imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [IW-1:0]     imem_rdata,
    output logic [IW-1:0]     inst,
    output logic [AW-1:0]     inst_pc,
    output logic              inst_valid,
    output logic [SCW-1:0]    stall_cnt,
    output logic              phase_err
);

`ifdef BENNETT_PREFETCH_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} fstate_t;
    fstate_t state, state_nxt;

    logic [AW-1:0] fetch_pc, req_addr, pend_pc;
    logic          pend, discard;
    logic [1:0]    cnt;
    logic [AW-1:0] fifo_pc   [2];
    logic [IW-1:0] fifo_data [2];
    logic          redirect, pop, push, start, wr_idx;

    always_comb begin
        redirect = inst_flag & pend;
        pop      = inst_flag & ~pend & (cnt != 2'd0);
        // a response landing on a redirect commit is stale and dropped with the flush
        push     = (state == F_WAIT) & imem_rvalid & ~discard & ~redirect;
        start    = (cnt < DEPTH) & ~redirect;
        wr_idx   = pop ? cnt[1] : cnt[0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= F_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        case (state)
            F_IDLE: if (start) state_nxt = F_REQ;
            F_REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) state_nxt = F_WAIT;
            end
            F_WAIT:  if (imem_rvalid) state_nxt = F_IDLE;
            default: state_nxt = F_IDLE;
        endcase
    end

    assign imem_addr = req_addr;

    // req_addr is latched separately so a redirect cannot move the address under a live request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            discard  <= 1'b0;
            pend     <= 1'b0;
            pend_pc  <= RESET_PC;
        end else begin
            if (state == F_IDLE && start) req_addr <= fetch_pc;
            if (redirect)
                fetch_pc <= pend_pc;
            else if (state == F_REQ && imem_gnt && !discard)
                fetch_pc <= fetch_pc + 1'b1;
            if (redirect && (state == F_REQ || (state == F_WAIT && !imem_rvalid)))
                discard <= 1'b1;
            else if (state == F_WAIT && imem_rvalid)
                discard <= 1'b0;
            if (pc_load) begin
                pend    <= 1'b1;
                pend_pc <= pc_target;
            end else if (redirect) begin
                pend    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                   cnt <= 2'd0;
        else if (redirect)              cnt <= 2'd0;
        else if (push && !pop)          cnt <= cnt + 2'd1;
        else if (pop && !push)          cnt <= cnt - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            fifo_pc[0]   <= fifo_pc[1];
            fifo_data[0] <= fifo_data[1];
        end
        if (push) begin
            fifo_pc[wr_idx]   <= req_addr;
            fifo_data[wr_idx] <= imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inst       <= NOP_INST;
            inst_pc    <= RESET_PC;
            inst_valid <= 1'b0;
            stall_cnt  <= '0;
            phase_err  <= 1'b0;
        end else begin
            // case inequality so an X on any phase also flags
            if (inst_flag && (clkp !== '0)) phase_err <= 1'b1;
            if (inst_flag) begin
                if (pend) begin
                    inst       <= NOP_INST;
                    inst_valid <= 1'b0;
                end else if (cnt != 2'd0) begin
                    inst       <= fifo_data[0];
                    inst_pc    <= fifo_pc[0];
                    inst_valid <= 1'b1;
                end else begin
                    inst       <= NOP_INST;
                    inst_valid <= 1'b0;
                    if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bennett_inst_sequencer.sv
// Bench for bennett_inst_sequencer: memory + Bennett phase models, queue-based reference, directed scenarios.
module tb_bennett_inst_sequencer;
    localparam int PHASES = 4, AW = 16, IW = 32, SCW = 8;
    localparam logic [IW-1:0] NOP = 32'h0;

    logic              clk = 1'b0, reset_n = 1'b0;
    logic              inst_flag = 1'b0, pc_load = 1'b0;
    logic [PHASES-1:0] clkp = '0;
    logic [AW-1:0]     pc_target = '0, imem_addr, inst_pc;
    logic              imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0, inst_valid, phase_err;
    logic [IW-1:0]     imem_rdata = '0, inst;
    logic [SCW-1:0]    stall_cnt;

    always #5 clk = ~clk;

    bennett_inst_sequencer dut (
        .clk(clk), .reset_n(reset_n), .inst_flag(inst_flag), .clkp(clkp),
        .pc_load(pc_load), .pc_target(pc_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
        .stall_cnt(stall_cnt), .phase_err(phase_err)
    );

    int checks = 0, errors = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] word(input logic [AW-1:0] a);
        return 32'h0000_00A0 + {16'h0, a};
    endfunction

    // stimulus knobs, written by the scenario block just after a rising edge
    logic          ben_en = 1'b0, gnt_block = 1'b0, ld_req = 1'b0, ld_sync = 1'b0, bad_req = 1'b0;
    logic [AW-1:0] ld_tgt = '0;
    int            rv_lat = 1;
    int            ncommit = 0;

    // reference model: fetched words wait in a queue, each commit takes one
    typedef struct { logic [AW-1:0] pc; logic [IW-1:0] data; } ent_t;
    ent_t           q[$];
    logic [IW-1:0]  exp_inst;
    logic [AW-1:0]  exp_pc, exp_fpc, ptgt, rsp_addr, req_hold;
    logic           exp_valid, exp_perr, pend, req_disc, rsp_pend, rsp_disc, req_seen;
    logic [SCW-1:0] exp_stall;
    int             rsp_cnt, k;

    task automatic model_reset();
        q.delete();
        exp_inst = NOP; exp_pc = '0; exp_valid = 0; exp_stall = '0; exp_perr = 0;
        exp_fpc = '0; pend = 0; ptgt = '0; req_disc = 0; rsp_pend = 0; rsp_disc = 0;
        rsp_cnt = 0; req_seen = 0; k = 0;
    endtask

    task automatic compare_outputs();
        check("inst", inst, exp_inst);
        check("inst_pc", inst_pc, exp_pc);
        check("inst_valid", inst_valid, exp_valid);
        check("stall_cnt", stall_cnt, exp_stall);
        check("phase_err", phase_err, exp_perr);
    endtask

    initial model_reset();

    always @(negedge clk) begin : tick
        logic fl, ld, gv, rv, rv_disc, redir;
        logic [PHASES-1:0] cp;
        logic [AW-1:0] rv_addr;
        ent_t e;
        if (!reset_n) begin
            model_reset();
            inst_flag = 0; pc_load = 0; imem_gnt = 0; imem_rvalid = 0; clkp = '0;
            compare_outputs();
            check("req_in_reset", imem_req, 0);
        end else begin
            compare_outputs();
            fl = 0; cp = '0;
            if (ben_en) begin
                k = (k == 9) ? 0 : k + 1;
                case (k)
                    1, 7: cp = 4'b0001;
                    2, 6: cp = 4'b0011;
                    3, 5: cp = 4'b0111;
                    4:    cp = 4'b1111;
                    default: cp = '0;
                endcase
                fl = (k == 9);
            end
            if (bad_req) begin fl = 1; cp = 4'b0001; bad_req = 0; end
            ld = 0;
            if (ld_req && (!ld_sync || fl)) begin ld = 1; ld_req = 0; end
            gv = 0; rv = 0;
            if (rsp_pend) begin
                rsp_cnt--;
                if (rsp_cnt == 0) rv = 1;
            end else if (imem_req && !gnt_block) begin
                gv = 1;
            end
            if (imem_req && req_seen) check("addr_stable", imem_addr, req_hold);
            req_seen = imem_req && !gv;
            req_hold = imem_addr;
            inst_flag = fl; clkp = cp; pc_load = ld; pc_target = ld_tgt;
            imem_gnt = gv; imem_rvalid = rv;
            imem_rdata = rv ? word(rsp_addr) : 32'hDEAD_BEEF;

            rv_disc = rsp_disc; rv_addr = rsp_addr;
            if (rv) rsp_pend = 0;
            if (gv) begin
                if (!req_disc) begin
                    check("fetch_addr", imem_addr, exp_fpc);
                    exp_fpc = exp_fpc + 1'b1;
                end
                rsp_pend = 1; rsp_cnt = rv_lat; rsp_addr = imem_addr;
                rsp_disc = req_disc; req_disc = 0;
            end
            redir = 0;
            if (fl) begin
                ncommit++;
                if (cp != '0) exp_perr = 1;
                if (pend) begin
                    redir = 1; exp_inst = NOP; exp_valid = 0; q.delete(); pend = 0;
                    exp_fpc = ptgt;
                    if (gv) rsp_disc = 1;
                    else if (imem_req) req_disc = 1;
                    else if (rsp_pend) rsp_disc = 1;
                end else if (q.size() > 0) begin
                    e = q.pop_front();
                    exp_inst = e.data; exp_pc = e.pc; exp_valid = 1;
                end else begin
                    exp_inst = NOP; exp_valid = 0;
                    if (exp_stall != '1) exp_stall = exp_stall + 1'b1;
                end
            end
            if (rv && !rv_disc && !redir) q.push_back('{rv_addr, word(rv_addr)});
            if (ld) begin pend = 1; ptgt = ld_tgt; end
        end
    end

    task automatic wait_commits(input int n);
        int tgt = ncommit + n;
        int budget = n * 12 + 40;
        while (ncommit < tgt && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (ncommit < tgt) check("commit_timeout", ncommit, tgt);
        #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : scenario
        int nv, b;
        repeat (3) @(posedge clk);
        #1;
        check("rst_inst", inst, NOP);
        check("rst_valid", inst_valid, 0);
        check("rst_addr", imem_addr, 0);
        reset_n = 1; ben_en = 1;

        // sequential fetch, fast memory
        wait_commits(1);
        check("t1_inst0", inst, 32'hA0);
        check("t1_pc0", inst_pc, 0);
        check("t1_valid0", inst_valid, 1);
        wait_commits(1);
        check("t1_inst1", inst, 32'hA1);
        wait_commits(1);
        check("t1_inst2", inst, 32'hA2);
        check("t1_stall", stall_cnt, 0);

        // redirect while a response is in flight
        rv_lat = 4;
        wait_commits(1);
        b = 0;
        while (!rsp_pend && b < 20) begin @(posedge clk); #1; b++; end
        check("t3_inflight", rsp_pend, 1);
        ld_tgt = 16'h0040; ld_sync = 0; ld_req = 1;
        wait_commits(1);
        check("t3_bubble", inst_valid, 0);
        check("t3_stall", stall_cnt, 0);
        wait_commits(1);
        check("t3_pc", inst_pc, 16'h0040);
        check("t3_inst", inst, 32'hE0);
        rv_lat = 1;

        // redirect requested in the commit cycle itself
        ld_tgt = 16'h0080; ld_sync = 1; ld_req = 1;
        wait_commits(1);
        check("t4_cur", inst_valid, 1);
        wait_commits(1);
        check("t4_bubble", inst_valid, 0);
        wait_commits(1);
        check("t4_pc", inst_pc, 16'h0080);
        check("t4_inst", inst, 32'h120);
        check("t4_stall", stall_cnt, 0);

        // slow memory: every other commit underruns
        rv_lat = 12;
        wait_commits(3);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            wait_commits(1);
            nv += int'(inst_valid);
        end
        check("t2_valid_count", nv, 4);

        // starve fetch entirely to saturate the stall counter
        gnt_block = 1;
        wait_commits(260);
        check("t2_sat", stall_cnt, 8'hFF);
        gnt_block = 0; rv_lat = 1;
        wait_commits(2);

        // commit pulse with a phase still high
        bad_req = 1;
        @(posedge clk); #1;
        check("t5_perr", phase_err, 1);
        repeat (30) @(posedge clk);
        #1;
        check("t5_perr_hold", phase_err, 1);

        // reset while a request waits for gnt
        gnt_block = 1;
        b = 0;
        while (!imem_req && b < 50) begin @(posedge clk); #1; b++; end
        check("t6_req", imem_req, 1);
        reset_n = 0;
        #1;
        check("t6_req_rst", imem_req, 0);
        check("t6_inst", inst, NOP);
        check("t6_pc", inst_pc, 0);
        check("t6_valid", inst_valid, 0);
        check("t6_stall", stall_cnt, 0);
        check("t6_perr", phase_err, 0);
        @(posedge clk); #1;
        reset_n = 1; gnt_block = 0; rv_lat = 1;
        wait_commits(1);
        check("t6_restart_pc", inst_pc, 0);
        check("t6_restart_inst", inst, 32'hA0);
        wait_commits(1);
        check("t6_next_inst", inst, 32'hA1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
